// File: rtl/rib_wait_ram.sv
// Word-organised RAM slave for RIB slave port 7 with programmable wait states
// and a four-phase req/ack handshake, modelling a slow on-chip memory.
module rib_wait_ram #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  output logic        ack_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    we_q;
  logic [31:0]             wdata;
  logic [31:0]             mem [DEPTH];
  logic                    start;
  logic                    commit;

  // Byte-offset and above-depth address bits are deliberately dropped (aliasing).
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  assign start  = (state == IDLE) && req_i;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_i) state_nxt = BUSY;
      BUSY: if (cnt == 4'd0) state_nxt = ACK;
      ACK:  state_nxt = req_i ? DONE : IDLE;
      DONE: if (!req_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ack_o  <= 1'b0;
      data_o <= 32'h0;
    end else begin
      state <= state_nxt;
      ack_o <= commit;
      if (start) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !we_q) begin
        data_o <= mem[idx];
      end
    end
  end

  // Request capture: only these copies are used once BUSY is entered.
  always_ff @(posedge clk) begin
    if (start) begin
      idx   <= addr_i[DEPTH_LOG2+1:2];
      we_q  <= we_i;
      wdata <= data_i;
    end
  end

  // A reset landing on the commit edge must suppress the write.
  always_ff @(posedge clk) begin
    if (rst && commit && we_q) begin
      mem[idx] <= wdata;
    end
  end

endmodule
